key_debounce: RTL

//  Front end for a push button: turns a raw, bouncy button pin into clean one-cycle event pulses.

---
 rtl/key_debounce.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// Push-button front end: two-flop synchroniser, debounce FSM and hold timer.
// Produces a clean pressed level plus one-cycle press, release, long-press and
// auto-repeat strobes. All strobes are registered and mutually exclusive.
module key_debounce #(
  parameter logic [23:0] CLK_FREQ       = 24'd12_000_000,
  parameter int          DEBOUNCE_MS    = 20,
  parameter int          LONG_MS        = 1000,
  parameter int          REPEAT_MS      = 200,
  parameter int          KEY_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned FREQ_KHZ = 32'(CLK_FREQ) / 32'd1000;
  localparam int unsigned DB_CYC   = FREQ_KHZ * 32'(DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = FREQ_KHZ * 32'(LONG_MS);
  localparam int unsigned REP_CYC  = FREQ_KHZ * 32'(REPEAT_MS);

  // Terminal counts: a counter reaching these values completes its interval.
  localparam logic [23:0] DB_LAST   = 24'(DB_CYC - 32'd1);
  localparam logic [23:0] LONG_LAST = 24'(LONG_CYC - 32'd1);
  localparam logic [23:0] REP_LAST  = 24'(REP_CYC - 32'd1);

  // Raw pin level that means "released"; the synchroniser resets to it.
  localparam logic REL_RAW = (KEY_ACTIVE_LOW != 0);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [23:0] dcnt_q, dcnt_d;
  logic [23:0] hcnt_q, hcnt_d;
  logic        long_flag_q, long_flag_d;
  logic        key_level_q, key_level_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        long_q, long_d;
  logic        repeat_q, repeat_d;
  logic        k;

  // Synchronised pin with polarity folded in: k = 1 means pressed.
  assign k = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  assign key_level     = key_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

  // Register every piece of state; reset returns to released/IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= REL_RAW;
      sync2_q     <= REL_RAW;
      dcnt_q      <= 24'd0;
      hcnt_q      <= 24'd0;
      long_flag_q <= 1'b0;
      key_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      long_flag_q <= long_flag_d;
      key_level_q <= key_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  // Next-state logic: debounce both edges, time the hold, issue strobes.
  always_comb begin
    state_d     = state_q;
    sync1_d     = key_raw;
    sync2_d     = sync1_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    long_flag_d = long_flag_q;
    key_level_d = key_level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (k) begin
          state_d = PRESS_DB;
          dcnt_d  = 24'd0;
        end
      end
      PRESS_DB: begin
        if (!k) begin
          state_d = IDLE;
        end else if (dcnt_q == DB_LAST) begin
          state_d     = HELD;
          press_d     = 1'b1;
          key_level_d = 1'b1;
          hcnt_d      = 24'd0;
        end else begin
          dcnt_d = dcnt_q + 24'd1;
        end
      end
      HELD: begin
        if (!k) begin
          // hcnt is left alone so a bounce does not lose hold progress.
          state_d = REL_DB;
          dcnt_d  = 24'd0;
        end else if (hcnt_q == LONG_LAST) begin
          state_d     = REPEAT;
          long_d      = 1'b1;
          long_flag_d = 1'b1;
          hcnt_d      = 24'd0;
        end else begin
          hcnt_d = hcnt_q + 24'd1;
        end
      end
      REPEAT: begin
        if (!k) begin
          state_d = REL_DB;
          dcnt_d  = 24'd0;
        end else if (hcnt_q == REP_LAST) begin
          repeat_d = 1'b1;
          hcnt_d   = 24'd0;
        end else begin
          hcnt_d = hcnt_q + 24'd1;
        end
      end
      REL_DB: begin
        if (k) begin
          // Release was a bounce: resume whichever hold phase was active.
          state_d = long_flag_q ? REPEAT : HELD;
        end else if (dcnt_q == DB_LAST) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          key_level_d = 1'b0;
          long_flag_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
